// File: rtl/sram_pkg.sv
// Shared constants and FSM encoding for the clocked mixed-signal SRAM bank.
// Analog levels are real-valued; the FSM sequences precharge, wordline and sense.
package sram_pkg;

   localparam real VDD     = 1.5;
   localparam real VSS     = 0.0;
   localparam real VTH     = 0.8;
   localparam real VDD_MIN = 1.2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      WL    = 3'd2,
      SENSE = 3'd3,
      DONE  = 3'd4
   } sram_state_t;

endpackage

// File: rtl/sram_level_cmp.sv
// Real-to-logic threshold: a level at or above VTH reads as 1.
module sram_level_cmp #(
   parameter real VTH = 0.8
) (
   input  real  level,
   output logic hi
);

   assign hi = (level >= VTH);

endmodule

// File: rtl/sram_bank.sv
// DEPTH x DATA_W SRAM bank with a precharge / wordline / sense request FSM.
// Array contents and written flags survive rst; the access FSM does not.
module sram_bank #(
   parameter int  DATA_W  = 8,
   parameter int  DEPTH   = 16,
   parameter real VDD     = sram_pkg::VDD,
   parameter real VSS     = sram_pkg::VSS,
   parameter real VTH     = sram_pkg::VTH,
   parameter real VDD_MIN = sram_pkg::VDD_MIN,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  real               r_wdata [DATA_W],
   output logic              rd_valid,
   output real               r_rdata [DATA_W],
   output logic              rd_uninit,
   output logic              rd_err,
   input  real               r_vdd,
   output real               r_wl [DEPTH],
   output real               r_bl_pre
);

   import sram_pkg::*;

   sram_state_t       state_reg, state_next;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              uninit_reg, err_reg;
   logic [DEPTH-1:0]  wl_reg, wl_next;
   logic              pre_reg, pre_next;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  written_reg = '0;

   logic [DATA_W-1:0] wdata_bits;
   logic              vdd_ok, brown, addr_ok, accept;
   logic              store_en, flag_clr, sense_en, abort_rd;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_wcmp
         sram_level_cmp #(.VTH(VTH)) u_cmp (.level(r_wdata[gi]), .hi(wdata_bits[gi]));
         assign r_rdata[gi] = rdata_reg[gi] ? VDD : VSS;
      end
      for (gi = 0; gi < DEPTH; gi++) begin : g_wl
         assign wl_next[gi] = (state_next == WL) && (addr_reg == ADDR_W'(gi));
         assign r_wl[gi]    = wl_reg[gi] ? VDD : VSS;
      end
   endgenerate

   sram_level_cmp #(.VTH(VDD_MIN)) u_vdd_cmp (.level(r_vdd), .hi(vdd_ok));

   assign brown     = !vdd_ok;
   assign req_ready = (state_reg == IDLE) && vdd_ok;
   assign accept    = req_valid && req_ready;
   assign addr_ok   = (32'(addr_reg) < DEPTH);
   assign pre_next  = (state_next == PRE);
   assign r_bl_pre  = pre_reg ? VDD : VSS;
   assign rd_valid  = (state_reg == DONE);
   assign rd_uninit = rd_valid && uninit_reg;
   assign rd_err    = rd_valid && err_reg;

   always_comb begin
      state_next = state_reg;
      store_en   = 1'b0;
      flag_clr   = 1'b0;
      sense_en   = 1'b0;
      abort_rd   = 1'b0;
      case (state_reg)
         IDLE: if (accept) state_next = PRE;
         PRE, WL: begin
            if (brown && we_reg) begin
               // An interrupted write leaves the word untrusted.
               state_next = IDLE;
               flag_clr   = addr_ok;
            end else if (brown) begin
               state_next = DONE;
               abort_rd   = 1'b1;
            end else if (state_reg == PRE) begin
               state_next = WL;
            end else if (we_reg) begin
               state_next = IDLE;
               store_en   = addr_ok;
            end else begin
               state_next = SENSE;
            end
         end
         SENSE: begin
            state_next = DONE;
            abort_rd   = brown;
            sense_en   = !brown;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         rdata_reg  <= '0;
         uninit_reg <= 1'b0;
         err_reg    <= 1'b0;
         wl_reg     <= '0;
         pre_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         wl_reg    <= wl_next;
         pre_reg   <= pre_next;
         if (accept) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= wdata_bits;
         end
         if (abort_rd || (sense_en && !addr_ok)) begin
            rdata_reg  <= '0;
            uninit_reg <= 1'b0;
            err_reg    <= 1'b1;
         end else if (sense_en) begin
            rdata_reg  <= written_reg[addr_reg] ? mem[addr_reg] : '0;
            uninit_reg <= !written_reg[addr_reg];
            err_reg    <= 1'b0;
         end
      end
   end

   // Storage has no reset so its contents outlive rst.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (store_en) begin
            mem[addr_reg]         <= wdata_reg;
            written_reg[addr_reg] <= 1'b1;
         end else if (flag_clr) begin
            written_reg[addr_reg] <= 1'b0;
         end
      end
   end

endmodule
